// File: rtl/rr_stream_mux.sv
// Round-robin N-channel valid/ready stream mux with a one-entry registered output buffer.
// Optional packet locking on in_last is enabled by defining RR_MUX_LAST_LOCK_EN.
module rr_stream_mux #(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel
`ifdef RR_MUX_LAST_LOCK_EN
  ,
  input  logic [N-1:0]       in_last,
  output logic               out_last
`endif
);

  // Handshake: a beat moves on any interface in a cycle where valid and ready are both 1
  // at the rising edge; valid never waits on ready, and in_ready is combinational.

  logic             load_en;
  logic             win_ok;
  logic             take;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] ptr_next;
  int               idx;

`ifdef RR_MUX_LAST_LOCK_EN
  logic             lock;
  logic [SEL_W-1:0] owner;
`endif

  assign load_en = !out_valid | out_ready;

  // Scan channels starting at rr_ptr with wrap-around; first valid channel wins.
  always_comb begin
    winner = '0;
    win_ok = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!win_ok && in_valid[idx]) begin
        winner = SEL_W'(idx);
        win_ok = 1'b1;
      end
    end
`ifdef RR_MUX_LAST_LOCK_EN
    if (lock) begin
      winner = owner;
      win_ok = in_valid[owner];
    end
`endif
  end

  assign take     = win_ok & load_en;
  assign ptr_next = (winner == SEL_W'(N - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    in_ready = '0;
    if (take && !rst) in_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
`ifdef RR_MUX_LAST_LOCK_EN
      out_last  <= 1'b0;
      lock      <= 1'b0;
      owner     <= '0;
`endif
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(winner)*WIDTH +: WIDTH];
      out_sel   <= winner;
`ifdef RR_MUX_LAST_LOCK_EN
      out_last  <= in_last[winner];
      // The pointer only moves at packet end so the next packet is arbitrated fairly.
      if (in_last[winner]) begin
        lock   <= 1'b0;
        rr_ptr <= ptr_next;
      end else begin
        lock   <= 1'b1;
        owner  <= winner;
      end
`else
      rr_ptr    <= ptr_next;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux (N=4, WIDTH=8): directed vector table, hand sequences for
// reset and packet lock, then randomized traffic against a reference model.
module tb_rr_stream_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic [3:0]  in_last;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(.N(4), .WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel)
`ifdef RR_MUX_LAST_LOCK_EN
    ,
    .in_last  (in_last),
    .out_last (out_last)
`endif
  );

`ifndef RR_MUX_LAST_LOCK_EN
  assign out_last = 1'b0;
`endif

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] id;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  sel;
  } vec_t;

  vec_t tbl[17];

  // Reference model state
  int          m_ptr, m_owner, m_sel;
  bit          m_lock;
  logic        m_valid, m_last;
  logic [7:0]  m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [3:0] iv, input logic [31:0] id, input logic ordy,
                       input logic [3:0] il);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    in_last   = il;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0; in_data = '0; out_ready = 1'b0; in_last = '0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_owner = 0; m_sel = 0; m_lock = 0;
    m_valid = 0; m_last = 0; m_data = '0;
  endtask

  function automatic int model_winner(input logic [3:0] iv);
    if (m_lock) return iv[m_owner] ? m_owner : -1;
    for (int i = 0; i < 4; i++)
      if (iv[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    return -1;
  endfunction

  initial begin
    logic [31:0] d;
    d = 32'h4433_2211;
    tbl[0]  = '{4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[1]  = '{4'b1111, d, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[2]  = '{4'b1111, d, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[3]  = '{4'b1111, d, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[4]  = '{4'b1111, d, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tbl[5]  = '{4'b1111, d, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[6]  = '{4'b1111, d, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[7]  = '{4'b1111, d, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
    tbl[8]  = '{4'b1111, d, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
    tbl[9]  = '{4'b1111, d, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
    tbl[10] = '{4'b1111, d, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[11] = '{4'b0100, d, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    tbl[12] = '{4'b1010, d, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    tbl[13] = '{4'b1010, d, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    tbl[14] = '{4'b0000, d, 1'b1, 4'b0000, 1'b0, 8'h22, 2'd1};
    tbl[15] = '{4'b0000, d, 1'b0, 4'b0000, 1'b0, 8'h22, 2'd1};
    tbl[16] = '{4'b0001, d, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0};

    // Reset state
    rst = 1'b1;
    in_valid = 4'b1111; in_data = d; out_ready = 1'b1; in_last = 4'b1111;
    #2;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_data", 32'(out_data), 0);
    check("reset_out_sel", 32'(out_sel), 0);
    check("reset_in_ready", 32'(in_ready), 0);
    check("reset_out_last", 32'(out_last), 0);
    tick();
    @(negedge clk);
    rst = 1'b0;

    // Directed table: all beats marked last so lock builds behave per beat
    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].iv, tbl[i].id, tbl[i].ordy, 4'b1111);
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      tick();
      check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      check($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
      check($sformatf("tbl%0d_out_sel", i), 32'(out_sel), 32'(tbl[i].sel));
    end

    // Reset mid-stream with out_valid=1 takes effect before the next clock edge
    apply(4'b1111, d, 1'b1, 4'b1111);
    check("pre_rst_out_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_in_ready", 32'(in_ready), 0);
    check("async_rst_out_sel", 32'(out_sel), 0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'b0001);
    tick();
    check("post_rst_out_sel", 32'(out_sel), 0);
    check("post_rst_out_data", 32'(out_data), 32'h11);

`ifdef RR_MUX_LAST_LOCK_EN
    // ch0 sends a 3-beat packet while ch1 waits
    begin
      logic [3:0] l_iv [4] = '{4'b0011, 4'b0011, 4'b0011, 4'b0010};
      logic [3:0] l_il [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b1111};
      logic [3:0] l_rdy[4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
      logic [1:0] l_sel[4] = '{2'd0, 2'd0, 2'd0, 2'd1};
      logic       l_lst[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
        apply(l_iv[i], d, 1'b1, l_il[i]);
        check($sformatf("lock%0d_in_ready", i), 32'(in_ready), 32'(l_rdy[i]));
        tick();
        check($sformatf("lock%0d_out_sel", i), 32'(out_sel), 32'(l_sel[i]));
        check($sformatf("lock%0d_out_last", i), 32'(out_last), 32'(l_lst[i]));
      end
    end
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 500; c++) begin
      logic [3:0]  iv, il;
      logic [31:0] id;
      logic        ordy;
      int          w;
      bit          load;
      iv   = 4'($urandom_range(0, 15));
      il   = 4'($urandom_range(0, 15));
      id   = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      apply(iv, id, ordy, il);
      load = !m_valid || ordy;
      w    = model_winner(iv);
      check("rand_in_ready", 32'(in_ready), (load && w >= 0) ? (32'd1 << w) : 32'd0);
      tick();
      if (load && w >= 0) begin
        m_valid = 1'b1;
        m_data  = id[w*8 +: 8];
        m_sel   = w;
`ifdef RR_MUX_LAST_LOCK_EN
        m_last  = il[w];
        if (il[w]) begin
          m_lock = 0;
          m_ptr  = (w + 1) % 4;
        end else begin
          m_lock  = 1;
          m_owner = w;
        end
`else
        m_ptr   = (w + 1) % 4;
`endif
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
      check("rand_out_valid", 32'(out_valid), 32'(m_valid));
      check("rand_out_data", 32'(out_data), 32'(m_data));
      check("rand_out_sel", 32'(out_sel), 32'(m_sel));
      check("rand_out_last", 32'(out_last), 32'(m_last));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
